data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory controller that sits directly downstream of `back_end`: it consumes the `dmem_wr_en`/`dmem_rd_en`/`dmem_addr`/`dmem_data_out` request port and produces `dmem_valid_in`/`dmem_data_in` back into it. It holds a word-organised on-chip data RAM behind a small FSM with a configurable access latency. Simulation and FPGA builds use this one block as the load/store backing store.

## Interface
- `DEPTH_WORDS`, 1024, number of 32-bit words; power of two, at least 4.
- `LATENCY`, 2, wait cycles between request acceptance and response; 0 to 15.
- `INIT_FILE`, "", hex file loaded with `$readmemh` at elaboration; an empty string leaves the RAM uninitialised.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dmem_wr_en`  in  1  store request; back_end holds it until `dmem_valid_in`.
- `dmem_rd_en`  in  1  load request; back_end holds it until `dmem_valid_in`.
- `dmem_addr`  in  32  byte address.
- `dmem_data_out`  in  32  store data from back_end.
- `dmem_valid_in`  out  1  one-cycle completion pulse for both loads and stores.
- `dmem_data_in`  out  32  load data; holds the last load result.
- `dmem_misaligned`  out  1  exists only with `DMEM_MISALIGN_TRAP_EN`.

## Operation
- States: IDLE, WAIT, RESP, GAP.
- IDLE:
  - When `dmem_wr_en` or `dmem_rd_en` is high, latch address, write data and kind.
  - Go to WAIT with counter = LATENCY-1, or go straight to RESP if LATENCY=0.
- Both enables high: treated as a store. No read is performed and only one response is returned.
- WAIT: the counter decrements each cycle. At 0 the transition is WAIT→RESP.
- Word index = `dmem_addr[2 +: log2(DEPTH_WORDS)]`. Upper bits are ignored, so out-of-range addresses wrap modulo the depth.
- Store commit: the RAM word is written on the clock edge that enters RESP.
- Load: RAM is read on the same edge, so `dmem_data_in` is valid in RESP.
- RESP:
  - `dmem_valid_in`=1 for exactly one cycle.
  - On a store, `dmem_data_in` is unchanged.
  - Next state is GAP.
- GAP: one turnaround cycle in which requests are ignored. This lets back_end drop its held request. Next state is IDLE.
- Requests arriving in WAIT, RESP or GAP are ignored. They are not queued.

## Timing
- Request first high in cycle 0 while in IDLE. `dmem_valid_in` is high in cycle LATENCY+1.
  - LATENCY=0: response in cycle 1.
  - LATENCY=2: response in cycle 3.
- GAP falls in cycle LATENCY+2. The earliest next acceptance is cycle LATENCY+3.
- Throughput: one access per LATENCY+3 cycles.
- Reset values: state IDLE, counter 0, `dmem_valid_in`=0, `dmem_data_in`=0, `dmem_misaligned`=0. RAM contents are not reset.
- Reset mid-operation:
  - Reset asserted in WAIT aborts the access. No RAM write, no response.
  - Reset in RESP leaves any store that already committed in place. The valid pulse ends.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `DMEM_MISALIGN_TRAP_EN`.
- Defined:
  - A request with `dmem_addr[1:0]`≠0 skips WAIT and performs no RAM access.
  - The response comes in cycle 1 with `dmem_valid_in`=1, `dmem_data_in`=0 and `dmem_misaligned`=1 for that cycle only. GAP follows as normal.
  - Aligned requests behave exactly as when the macro is undefined, with `dmem_misaligned`=0.
- Undefined:
  - The `dmem_misaligned` port is absent.
  - `dmem_addr[1:0]` is ignored, so every access is forced to be word-aligned.

## Test plan
- Reset then load, LATENCY=2: `INIT_FILE` word 3 = 0xDEADBEEF, hold rd at addr 0x0C → valid only in cycle 3 with data 0xDEADBEEF; next acceptance in cycle 5.
- Store then load: wr addr 0x10 data 0x00000004, then rd 0x10 → store valid after 3 cycles; load returns 0x00000004; `dmem_data_in` is unchanged during the store response.
- Simultaneous rd and wr at addr 0x20 with data 0x55 → a single valid pulse; `dmem_data_in` is unchanged; a later rd of 0x20 returns 0x55.
- Wrap-around, DEPTH_WORDS=1024: wr 0x1000 data 0xA5 → rd 0x0 returns 0xA5.
- Reset mid-WAIT: wr 0x8 data 0x77, reset asserted in cycle 1 → no valid pulse; a later rd of 0x8 returns the prior contents, not 0x77.
- With `DMEM_MISALIGN_TRAP_EN`: rd at 0x6 → cycle 1 has valid=1, misaligned=1, data 0; a following aligned rd has misaligned=0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data RAM behind an IDLE/WAIT/RESP/GAP FSM with LATENCY wait cycles.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_wr_en,
  input  logic        dmem_rd_en,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data_out,
  output logic        dmem_valid_in,
  output logic [31:0] dmem_data_in
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        dmem_misaligned
`endif
);

  localparam int         IDX_W      = $clog2(DEPTH_WORDS);
  localparam bit         LAT_ZERO   = (LATENCY == 0);
  localparam logic [3:0] LAT_RELOAD = LAT_ZERO ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [3:0]         cnt_r;
  logic [3:0]         cnt_nx_s;
  logic [IDX_W-1:0]   idx_r;
  logic [31:0]        wdata_r;
  logic               is_wr_r;
  logic               valid_r;
  logic [31:0]        data_r;
  logic               mis_r;

  logic               req_s;
  logic               mis_s;
  logic               unused_s;
  logic [IDX_W-1:0]   in_idx_s;
  logic [IDX_W-1:0]   acc_idx_s;
  logic [31:0]        acc_wdata_s;
  logic               acc_wr_s;
  logic               trap_s;
  logic               enter_resp_s;
  logic               ram_we_s;
  logic               ram_re_s;

  logic [31:0]        mem_r [DEPTH_WORDS];

  assign req_s    = dmem_wr_en | dmem_rd_en;
  assign in_idx_s = dmem_addr[2 +: IDX_W];

  // Upper address bits wrap; the byte offset only matters when trapping.
`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_s    = (dmem_addr[1:0] != 2'b00);
  assign unused_s = ^dmem_addr[31:2+IDX_W];
`else
  assign mis_s    = 1'b0;
  assign unused_s = ^{dmem_addr[31:2+IDX_W], dmem_addr[1:0]};
`endif

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (LAT_ZERO || mis_s) begin
            state_nx_s = ST_RESP;
          end else begin
            state_nx_s = ST_WAIT;
            cnt_nx_s   = LAT_RELOAD;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx_s = ST_RESP;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: state_nx_s = ST_GAP;
      ST_GAP:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Access selection: the live request in IDLE (zero-latency or trap), else the latched one
  always_comb begin
    acc_idx_s   = idx_r;
    acc_wdata_s = wdata_r;
    acc_wr_s    = is_wr_r;
    trap_s      = 1'b0;
    if (state_r == ST_IDLE) begin
      acc_idx_s   = in_idx_s;
      acc_wdata_s = dmem_data_out;
      acc_wr_s    = dmem_wr_en;
      trap_s      = req_s & mis_s;
    end else begin
      trap_s      = 1'b0;
    end
    enter_resp_s = (state_nx_s == ST_RESP);
    ram_we_s     = enter_resp_s & acc_wr_s & ~trap_s & ~rst;
    ram_re_s     = enter_resp_s & ~acc_wr_s & ~trap_s;
  end

  // Request capture on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= {IDX_W{1'b0}};
      wdata_r <= 32'd0;
      is_wr_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && req_s) begin
      idx_r   <= in_idx_s;
      wdata_r <= dmem_data_out;
      is_wr_r <= dmem_wr_en;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[acc_idx_s] <= acc_wdata_s;
    end
  end

  // Registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= 32'd0;
      mis_r   <= 1'b0;
    end else begin
      valid_r <= enter_resp_s;
      mis_r   <= trap_s;
      if (trap_s) begin
        data_r <= 32'd0;
      end else if (ram_re_s) begin
        data_r <= mem_r[acc_idx_s];
      end
    end
  end

  assign dmem_valid_in = valid_r;
  assign dmem_data_in  = data_r;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign dmem_misaligned = mis_r;
`else
  logic unused_mis_s;
  assign unused_mis_s = mis_r;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: randomized loads/stores against an array model
// with response-cycle prediction; also covers DMEM_MISALIGN_TRAP_EN when defined.
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    int          cyc;
    bit          upd;
    logic [31:0] data;
    bit          mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_wr_en = 1'b0;
  logic        dmem_rd_en = 1'b0;
  logic [31:0] dmem_addr = 32'd0;
  logic [31:0] dmem_data_out = 32'd0;
  logic        dmem_valid_in;
  logic [31:0] dmem_data_in;
  logic        mis_out;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        rst_q = 1'b0;
  int          next_free = 0;
  logic [31:0] hold = 32'd0;
  logic [31:0] model_mem [DEPTH];
  exp_t        sb_q [$];
  exp_t        mon_e;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk),
    .rst(rst),
    .dmem_wr_en(dmem_wr_en),
    .dmem_rd_en(dmem_rd_en),
    .dmem_addr(dmem_addr),
    .dmem_data_out(dmem_data_out),
    .dmem_valid_in(dmem_valid_in),
    .dmem_data_in(dmem_data_in)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .dmem_misaligned(mis_out)
`endif
  );

`ifndef DMEM_MISALIGN_TRAP_EN
  assign mis_out = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Monitor: reset state, response contents/timing, and data hold between responses
  always @(negedge clk) begin
    if (rst_q) begin
      checks++;
      if (dmem_valid_in !== 1'b0 || dmem_data_in !== 32'd0 || mis_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: valid=%b data=%h mis=%b, expected 0 00000000 0",
                 dmem_valid_in, dmem_data_in, mis_out);
      end
      hold = 32'd0;
    end else if (dmem_valid_in === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: valid=1 in cycle %0d, expected no response", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.upd) hold = mon_e.data;
        if (cyc != mon_e.cyc || dmem_data_in !== hold || mis_out !== mon_e.mis) begin
          errors++;
          $display("FAIL response: cycle=%0d data=%h mis=%b, expected cycle=%0d data=%h mis=%b",
                   cyc, dmem_data_in, mis_out, mon_e.cyc, hold, mon_e.mis);
        end
      end
    end else begin
      checks++;
      if (dmem_valid_in !== 1'b0 || dmem_data_in !== hold || mis_out !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: cycle=%0d valid=%b data=%h mis=%b, expected 0 %h 0",
                 cyc, dmem_valid_in, dmem_data_in, mis_out, hold);
      end
    end
  end

  // Issue one request, predict its response, hold it until valid (bounded)
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int unsigned idx;
    int          acc;
    bit          mis;
    bit          got;
    @(posedge clk);
    #1;
    idx = (addr >> 2) % DEPTH;
    mis = TRAP && (addr[1:0] != 2'b00);
    acc = (cyc > next_free) ? cyc : next_free;
    e.cyc = acc + (mis ? 1 : LAT + 1);
    next_free = e.cyc + 2;
    e.mis = mis;
    if (mis) begin
      e.upd = 1'b1;
      e.data = 32'd0;
    end else if (wr) begin
      model_mem[idx] = wd;
      e.upd = 1'b0;
      e.data = 32'd0;
    end else begin
      e.upd = 1'b1;
      e.data = model_mem[idx];
    end
    sb_q.push_back(e);
    dmem_wr_en = wr;
    dmem_rd_en = rd;
    dmem_addr = addr;
    dmem_data_out = wd;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk);
      #1;
      if (dmem_valid_in === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout: no valid for addr %h within 64 cycles, expected one", addr);
    end
    dmem_wr_en = 1'b0;
    dmem_rd_en = 1'b0;
  endtask

  initial begin
    int          op;
    int unsigned widx;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Give the exercised words known contents
    for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 32'(i * 4), $urandom);

    access(1'b1, 1'b0, 32'h10, 32'h0000_0004);
    access(1'b0, 1'b1, 32'h10, 32'd0);
    access(1'b1, 1'b1, 32'h20, 32'h0000_0055);
    access(1'b0, 1'b1, 32'h20, 32'd0);
    access(1'b1, 1'b0, 32'h1000, 32'h0000_00A5);
    access(1'b0, 1'b1, 32'h0, 32'd0);
    access(1'b0, 1'b1, 32'h6, 32'd0);
    access(1'b0, 1'b1, 32'h4, 32'd0);

    // Store aborted by reset while waiting; word 0x8 must keep its prior value
    access(1'b1, 1'b0, 32'h8, 32'h0000_0011);
    repeat (2) @(posedge clk);
    #1;
    dmem_wr_en = 1'b1;
    dmem_addr = 32'h8;
    dmem_data_out = 32'h0000_0077;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    dmem_wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_free = 0;
    repeat (4) @(posedge clk);
    access(1'b0, 1'b1, 32'h8, 32'd0);

    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      op = $urandom_range(0, 2);
      widx = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_F000) | 32'(widx << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      access(op != 0, op != 1, a, $urandom);
    end

    repeat (6) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
